// File: rtl/cpu_pkg.sv
// Shared datapath definitions: IR field positions, auto-sequence states
// and the seq_field encodings seen by the control unit.
package cpu_pkg;

  // Register-field bit positions inside the instruction register
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;

  // Auto-sequence walks Rb, Rc, Ra on consecutive cycles
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEL_B = 2'd1,
    SEL_C = 2'd2,
    SEL_A = 2'd3
  } seq_state_t;

  // Field currently driven by the sequence
  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_RB   = 2'd1;
  localparam logic [1:0] FIELD_RC   = 2'd2;
  localparam logic [1:0] FIELD_RA   = 2'd3;

endpackage

// File: rtl/ir_field_mux.sv
// Combinational priority select of the Ra/Rb/Rc fields (gra > grb > grc)
// with detection of conflicting field requests.
module ir_field_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic [DATA_W-1:0] ir,
  input  logic              gra,
  input  logic              grb,
  input  logic              grc,
  output logic [IDX_W-1:0]  idx,
  output logic              any_sel,
  output logic              sel_err
);

  // Priority field select; sel_err flags two or more requests at once
  always_comb begin
    idx = '0;
    if (gra)      idx = ir[RA_HI:RA_LO];
    else if (grb) idx = ir[RB_HI:RB_LO];
    else if (grc) idx = ir[RC_HI:RC_LO];
    any_sel = gra | grb | grc;
    sel_err = (gra & grb) | (gra & grc) | (grb & grc);
  end

endmodule

// File: rtl/ir_select_encode.sv
// Instruction register, register-index encoder and Rb/Rc/Ra auto-sequence.
// Handshake: none; gra/grb/grc/rin/rout/ba_out are sampled every clock in
// IDLE and all outputs appear one clock later; seq_start is a one-cycle
// pulse accepted only in IDLE.
// Optional feature macro: BA_ZERO_EN (R0 under ba_out raises ba_zero and
// suppresses rout_en so the bus reads zero).
module ir_select_encode
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4,
  parameter int C_W    = 19
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              ir_in,
  input  logic              gra,
  input  logic              grb,
  input  logic              grc,
  input  logic              rin,
  input  logic              rout,
  input  logic              ba_out,
  input  logic              seq_start,
  output logic [IDX_W-1:0]  reg_idx,
  output logic              rin_en,
  output logic              rout_en,
  output logic              ba_zero,
  output logic [DATA_W-1:0] c_sext,
  output logic [DATA_W-1:0] ir_q,
  output logic              seq_busy,
  output logic [1:0]        seq_field,
  output logic              sel_err
);

  seq_state_t       state;
  logic [IDX_W-1:0] snap_ra;
  logic [IDX_W-1:0] snap_rc;
  logic [IDX_W-1:0] sel_idx;
  logic             any_sel;
  logic             mux_err;
  logic             man_rin;
  logic             man_rout;
  logic             man_bz;

  ir_field_mux #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_field_mux (
    .ir      (ir_q),
    .gra     (gra),
    .grb     (grb),
    .grc     (grc),
    .idx     (sel_idx),
    .any_sel (any_sel),
    .sel_err (mux_err)
  );

  // IR loads whenever ir_in is high, even mid-sequence (sequence uses snapshot)
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) ir_q <= '0;
    else if (ir_in) ir_q <= bus_in;
  end

  // Constant field sign-extended onto the bus width
  assign c_sext = {{(DATA_W-C_W){ir_q[C_W-1]}}, ir_q[C_W-1:0]};

  // Manual-mode next values for the qualifiers
  always_comb begin
    man_bz = 1'b0;
`ifdef BA_ZERO_EN
    man_bz = ba_out & any_sel & (sel_idx == '0);
`endif
    man_rin  = rin & any_sel;
    man_rout = (rout | ba_out) & any_sel & ~man_bz;
  end

  // Sequence FSM and all registered decoder-side outputs
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      snap_ra <= '0;
      snap_rc <= '0;
      reg_idx <= '0;
      rin_en  <= 1'b0;
      rout_en <= 1'b0;
      ba_zero <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (seq_start) begin
            // Sequence wins over any same-cycle manual request
            state   <= SEL_B;
            snap_ra <= ir_q[RA_HI:RA_LO];
            snap_rc <= ir_q[RC_HI:RC_LO];
            reg_idx <= ir_q[RB_HI:RB_LO];
            rin_en  <= 1'b0;
            rout_en <= 1'b1;
            ba_zero <= 1'b0;
            sel_err <= 1'b0;
          end else begin
            if (any_sel) reg_idx <= sel_idx;
            rin_en  <= man_rin;
            rout_en <= man_rout;
            ba_zero <= man_bz;
            sel_err <= mux_err;
          end
        end
        SEL_B: begin
          state   <= SEL_C;
          reg_idx <= snap_rc;
          rin_en  <= 1'b0;
          rout_en <= 1'b1;
        end
        SEL_C: begin
          state   <= SEL_A;
          reg_idx <= snap_ra;
          rin_en  <= 1'b1;
          rout_en <= 1'b0;
        end
        SEL_A: begin
          state   <= IDLE;
          rin_en  <= 1'b0;
          rout_en <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // State exposure for the control unit and debug
  always_comb begin
    seq_busy = (state != IDLE);
    case (state)
      SEL_B:   seq_field = FIELD_RB;
      SEL_C:   seq_field = FIELD_RC;
      SEL_A:   seq_field = FIELD_RA;
      default: seq_field = FIELD_NONE;
    endcase
  end

endmodule

// File: tb/tb_ir_select_encode.sv
// Directed bench for ir_select_encode: expected decoder-side outputs are
// queued as each cycle's stimulus is driven and popped one clock later.
module tb_ir_select_encode;

  localparam int DATA_W = 32;
  localparam int IDX_W  = 4;
  localparam int C_W    = 19;
  localparam int W      = 11;

  logic              clock;
  logic              clear;
  logic [DATA_W-1:0] bus_in;
  logic              ir_in, gra, grb, grc, rin, rout, ba_out, seq_start;
  logic [IDX_W-1:0]  reg_idx;
  logic              rin_en, rout_en, ba_zero, seq_busy, sel_err;
  logic [DATA_W-1:0] c_sext, ir_q;
  logic [1:0]        seq_field;

  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  ir_select_encode #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .C_W    (C_W)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .bus_in    (bus_in),
    .ir_in     (ir_in),
    .gra       (gra),
    .grb       (grb),
    .grc       (grc),
    .rin       (rin),
    .rout      (rout),
    .ba_out    (ba_out),
    .seq_start (seq_start),
    .reg_idx   (reg_idx),
    .rin_en    (rin_en),
    .rout_en   (rout_en),
    .ba_zero   (ba_zero),
    .c_sext    (c_sext),
    .ir_q      (ir_q),
    .seq_busy  (seq_busy),
    .seq_field (seq_field),
    .sel_err   (sel_err)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [W-1:0] pk(input logic [3:0] idx, input logic ri,
                                      input logic ro, input logic bz,
                                      input logic er, input logic bs,
                                      input logic [1:0] fld);
    return {idx, ri, ro, bz, er, bs, fld};
  endfunction

  function automatic logic [W-1:0] observed();
    return {reg_idx, rin_en, rout_en, ba_zero, sel_err, seq_busy, seq_field};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic a, input logic b, input logic c,
                       input logic ri, input logic ro, input logic ba,
                       input logic ss);
    gra = a; grb = b; grc = c; rin = ri; rout = ro; ba_out = ba; seq_start = ss;
  endtask

  task automatic load(input logic [DATA_W-1:0] v);
    bus_in = v; ir_in = 1'b1;
  endtask

  // Advance one clock and compare against the oldest queued expectation
  task automatic tick_check(input string tag);
    logic [W-1:0] e;
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s observed=0x%0h expected=<empty queue>", tag, observed());
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(observed()), 32'(e));
    end
    ir_in = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    clear = 1'b1;
    bus_in = '0;
    ir_in = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // Reset state
    #2 clear = 1'b0;
    #1;
    check("reset_outputs", 32'(observed()), 32'(pk(0, 0, 0, 0, 0, 0, 0)));
    check("reset_ir", ir_q, 32'h0);
    #4 clear = 1'b1;

    // IR load: Ra=5 Rb=3 Rc=8, constant field negative
    load(32'h0A9C_0005);
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 0));
    tick_check("load_ir1");
    check("ir_q_1", ir_q, 32'h0A9C_0005);
    check("c_sext_1", c_sext, 32'hFFFC_0005);

    // Manual Rb read
    drive(0, 1, 0, 0, 1, 0, 0);
    exp_q.push_back(pk(3, 0, 1, 0, 0, 0, 0));
    tick_check("grb_rout");

    // Priority gra over grb, conflict flagged
    drive(1, 1, 0, 1, 0, 0, 0);
    exp_q.push_back(pk(5, 1, 0, 0, 1, 0, 0));
    tick_check("gra_grb_prio");

    // Single grc clears sel_err
    drive(0, 0, 1, 0, 0, 0, 0);
    exp_q.push_back(pk(8, 0, 0, 0, 0, 0, 0));
    tick_check("grc_only");

    // Nothing selected: index holds, rin not qualified
    drive(0, 0, 0, 1, 1, 0, 0);
    exp_q.push_back(pk(8, 0, 0, 0, 0, 0, 0));
    tick_check("no_select_hold");

    // All three: gra wins
    drive(1, 1, 1, 0, 1, 0, 0);
    exp_q.push_back(pk(5, 0, 1, 0, 1, 0, 0));
    tick_check("all_three");

    // Constant boundaries
    load(32'h0004_0000);
    exp_q.push_back(pk(5, 0, 0, 0, 0, 0, 0));
    tick_check("load_neg_c");
    check("c_sext_neg", c_sext, 32'hFFFC_0000);
    load(32'h0003_FFFF);
    exp_q.push_back(pk(5, 0, 0, 0, 0, 0, 0));
    tick_check("load_pos_c");
    check("c_sext_pos", c_sext, 32'h0003_FFFF);

    // Index 15 is legal
    load(32'h0780_0000);
    exp_q.push_back(pk(5, 0, 0, 0, 0, 0, 0));
    tick_check("load_ra15");
    drive(1, 0, 0, 1, 0, 0, 0);
    exp_q.push_back(pk(15, 1, 0, 0, 0, 0, 0));
    tick_check("ra15_rin");

    // Auto-sequence Ra=1 Rb=2 Rc=4; same-cycle manual request dropped
    load(32'h0092_0000);
    exp_q.push_back(pk(15, 0, 0, 0, 0, 0, 0));
    tick_check("load_seq1");
    drive(1, 0, 0, 1, 0, 0, 1);
    exp_q.push_back(pk(2, 0, 1, 0, 0, 1, 1));
    tick_check("seq1_b");
    exp_q.push_back(pk(4, 0, 1, 0, 0, 1, 2));
    tick_check("seq1_c");
    exp_q.push_back(pk(1, 1, 0, 0, 0, 1, 3));
    tick_check("seq1_a");
    exp_q.push_back(pk(1, 0, 0, 0, 0, 0, 0));
    tick_check("seq1_done");

    // Busy interference: restart, manual and IR load during SEL_B
    drive(0, 0, 0, 0, 0, 0, 1);
    exp_q.push_back(pk(2, 0, 1, 0, 0, 1, 1));
    tick_check("seq2_b");
    load(32'h03CD_8000);
    drive(0, 0, 1, 1, 0, 0, 1);
    exp_q.push_back(pk(4, 0, 1, 0, 0, 1, 2));
    tick_check("seq2_c");
    check("ir_q_busy_load", ir_q, 32'h03CD_8000);
    drive(1, 0, 0, 0, 1, 0, 0);
    exp_q.push_back(pk(1, 1, 0, 0, 0, 1, 3));
    tick_check("seq2_a");
    exp_q.push_back(pk(1, 0, 0, 0, 0, 0, 0));
    tick_check("seq2_done");
    exp_q.push_back(pk(1, 0, 0, 0, 0, 0, 0));
    tick_check("no_restart");
    drive(0, 1, 0, 0, 1, 0, 0);
    exp_q.push_back(pk(9, 0, 1, 0, 0, 0, 0));
    tick_check("new_rb");

    // Reset in SEL_C
    drive(0, 0, 0, 0, 0, 0, 1);
    exp_q.push_back(pk(9, 0, 1, 0, 0, 1, 1));
    tick_check("seq3_b");
    exp_q.push_back(pk(11, 0, 1, 0, 0, 1, 2));
    tick_check("seq3_c");
    #2 clear = 1'b0;
    #1;
    check("mid_reset_outputs", 32'(observed()), 32'(pk(0, 0, 0, 0, 0, 0, 0)));
    check("mid_reset_ir", ir_q, 32'h0);
    #1 clear = 1'b1;
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 0));
    tick_check("after_reset_idle");

    // Base-address read of R0 and of a non-zero register
    load(32'h0008_0000);
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 0));
    tick_check("load_ra0");
    drive(1, 0, 0, 0, 0, 1, 0);
`ifdef BA_ZERO_EN
    exp_q.push_back(pk(0, 0, 0, 1, 0, 0, 0));
`else
    exp_q.push_back(pk(0, 0, 1, 0, 0, 0, 0));
`endif
    tick_check("ba_r0");
    load(32'h0300_0000);
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 0));
    tick_check("load_ra6");
    drive(1, 0, 0, 0, 0, 1, 0);
    exp_q.push_back(pk(6, 0, 1, 0, 0, 0, 0));
    tick_check("ba_r6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ir_select_encode.md
Name: ir_select_encode

Overview:
- Upstream neighbour of the 4-to-16 register decoder in the datapath.
- Holds the 32-bit instruction register (IR) and extracts the Ra/Rb/Rc fields.
- Produces the registered 4-bit register index that drives the decoder, plus Rin/Rout qualifiers and the sign-extended C constant for the bus.
- Provides manual control (Gra/Grb/Grc from the control unit) and an auto-sequence mode that walks Rb, Rc, Ra on consecutive cycles.

Parameters:
- DATA_W, 32, bus and IR width.
- IDX_W, 4, register-index width; decoder input width.
- C_W, 19, width of the IR constant field, IR[C_W-1:0].

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  asynchronous, active-low reset.
- bus_in  in  DATA_W  bus value loaded into IR.
- ir_in  in  1  IR load enable.
- gra  in  1  select the Ra field, IR[26:23].
- grb  in  1  select the Rb field, IR[22:19].
- grc  in  1  select the Rc field, IR[18:15].
- rin  in  1  write-qualifier request.
- rout  in  1  read-qualifier request.
- ba_out  in  1  base-address read request.
- seq_start  in  1  start the auto-sequence (pulse).
- reg_idx  out  IDX_W  register index to the decoder.
- rin_en  out  1  qualified write enable.
- rout_en  out  1  qualified read enable.
- ba_zero  out  1  R0 selected under ba_out; the bus must drive 0.
- c_sext  out  DATA_W  IR[C_W-1:0] sign-extended.
- ir_q  out  DATA_W  IR contents.
- seq_busy  out  1  auto-sequence active.
- seq_field  out  2  current field: 0 = none, 1 = Rb, 2 = Rc, 3 = Ra.
- sel_err  out  1  more than one of gra/grb/grc asserted.

Behaviour:
- Reset (clear = 0, asynchronous):
  - ir_q = 0, reg_idx = 0.
  - rin_en, rout_en, ba_zero, sel_err, seq_busy = 0; seq_field = 0.
  - FSM returns to IDLE, including mid-sequence.
- IR:
  - ir_q <= bus_in on the clock edge when ir_in = 1.
  - c_sext is combinational from ir_q: replicate bit C_W-1 into the upper bits.
- Manual mode (FSM in IDLE): all outputs are registered, 1-cycle latency from gra/grb/grc, rin, rout, ba_out.
  - Field priority: gra > grb > grc. If none is asserted, reg_idx holds its previous value.
  - rin_en <= rin & (gra|grb|grc).
  - rout_en <= (rout|ba_out) & (gra|grb|grc).
  - sel_err <= 1 when 2 or more of gra/grb/grc are high in the same cycle; it is still registered one cycle later.
- Auto-sequence FSM: states IDLE, SEL_B, SEL_C, SEL_A.
  - IDLE -> SEL_B on seq_start. Ra/Rb/Rc are snapshotted from ir_q on that edge.
  - SEL_B -> SEL_C -> SEL_A -> IDLE, one cycle each. seq_busy = 1 throughout.
  - Outputs per state:
    - SEL_B: reg_idx = Rb, rout_en = 1.
    - SEL_C: reg_idx = Rc, rout_en = 1.
    - SEL_A: reg_idx = Ra, rin_en = 1.
    - seq_field tracks the state, encoded as in the port list.
  - While busy, manual gra/grb/grc/rin/rout are ignored.
  - seq_start while busy is ignored; there is no restart.
  - ir_in while busy updates ir_q, but the sequence uses the snapshot.
  - seq_start and a manual request in the same IDLE cycle: the sequence wins and the manual request is dropped.
- Index arithmetic: fields are unsigned 4-bit, with no wrap or carry. Index 15 is legal.

Optional Feature:
- BA_ZERO_EN
  - Defined: ba_zero <= ba_out & (selected index == 0), registered with reg_idx. rout_en is suppressed in that cycle so R0 does not drive the bus.
  - Undefined: ba_zero is tied 0 and ba_out behaves exactly as rout.

Decomposition:
- Shared package (cpu_pkg):
  - Field bit positions RA_HI/RA_LO, RB_HI/RB_LO, RC_HI/RC_LO.
  - The seq_state enum (IDLE, SEL_B, SEL_C, SEL_A).
  - The seq_field encodings.
- One natural sub-module, ir_field_mux: priority select of Ra/Rb/Rc plus sel_err detection. It is purely combinational and is instantiated once.

Test Plan:
- Reset: clear = 0 mid-sequence (in SEL_C) -> next sample shows seq_busy = 0, reg_idx = 0, ir_q = 0, all enables 0.
- IR load and constant: bus_in = 0x0A9C_0005, ir_in = 1, then grb = 1, rout = 1 -> one cycle later reg_idx = 3, rout_en = 1. Load IR[18:0] = 0x40000 -> c_sext = 0xFFFC_0000.
- Priority: gra = grb = 1 with IR Ra = 5, Rb = 3 -> reg_idx = 5, sel_err = 1. Next cycle with only grc -> sel_err = 0.
- Sequence: Ra = 1, Rb = 2, Rc = 4, pulse seq_start -> reg_idx 2/4/1 on three consecutive cycles. rout_en = 1, 1, 0; rin_en = 0, 0, 1. seq_busy low on the 4th cycle.
- Busy interference: second seq_start and ir_in with new fields in SEL_B -> sequence completes with the snapshot fields, ir_q shows the new value, no second sequence.
- BA_ZERO_EN defined: Ra = 0, gra = 1, ba_out = 1 -> ba_zero = 1, rout_en = 0. Ra = 6 -> ba_zero = 0, rout_en = 1.
